// File: rtl/barrel_arb_pkg.sv
// -----------------------------------------------------------------------------
// barrel_arb_pkg
// Shared definitions for the two-port barrel-shift arbiter:
//   DW, SW              - data width and shift-amount width
//   DIR_LEFT, DIR_RIGHT - encodings of the dir inputs
//   state_t             - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package barrel_arb_pkg;

    localparam int DW = 8;
    localparam int SW = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/barrel_arb_barrel.sv
// -----------------------------------------------------------------------------
// barrel
// Purely combinational 8-bit logical shifter with zero fill.
//   inp_  [7:0]  operand
//   shamt [2:0]  shift amount 0..7 (0 passes inp_ through)
//   dir          DIR_LEFT = shift left, DIR_RIGHT = shift right
//   out_  [7:0]  shifted result, truncated to 8 bits
// -----------------------------------------------------------------------------
module barrel
    import barrel_arb_pkg::*;
(
    input  logic [DW-1:0] inp_,
    input  logic [SW-1:0] shamt,
    input  logic          dir,
    output logic [DW-1:0] out_
);

    always_comb begin
        if (dir == DIR_LEFT) out_ = inp_ << shamt;
        else                 out_ = inp_ >> shamt;
    end

endmodule

// File: rtl/barrel_arb.sv
// -----------------------------------------------------------------------------
// barrel_arb
// Two-port round-robin arbiter in front of a single shared barrel shifter.
// One operation takes three cycles: IDLE (arbitrate + capture) -> SHIFT
// (load result) -> DONE (valid pulse, pointer update) -> IDLE.
//   clk, rst                  clock, asynchronous active-high reset
//   req0/data0/shamt0/dir0    port 0 request and operands
//   req1/data1/shamt1/dir1    port 1 request and operands
//   gnt0, gnt1                one-cycle grant pulses (operands captured)
//   out_                      registered shift result
//   valid                     one-cycle pulse, out_/owner meaningful
//   owner                     port that owns the current out_
//   busy                      high whenever the FSM is not in IDLE
// All outputs are flops.
// -----------------------------------------------------------------------------
module barrel_arb
    import barrel_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    input  logic [SW-1:0] shamt0,
    input  logic          dir0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    input  logic [SW-1:0] shamt1,
    input  logic          dir1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] out_,
    output logic          valid,
    output logic          owner,
    output logic          busy
);

    state_t        state, state_nxt;
    logic [DW-1:0] op_data, op_data_nxt;
    logic [SW-1:0] op_shamt, op_shamt_nxt;
    logic          op_dir, op_dir_nxt;
    logic          op_port, op_port_nxt;
    logic          last_served, last_served_nxt;
    logic          gnt0_nxt, gnt1_nxt, valid_nxt, owner_nxt, busy_nxt;
    logic [DW-1:0] out_nxt;
    logic [DW-1:0] shift_res;
    logic          win;

    // Contention goes to the port not served last; a lone requester always wins.
    assign win = (req0 && req1) ? ~last_served : req1;

    barrel u_barrel (
        .inp_  (op_data),
        .shamt (op_shamt),
        .dir   (op_dir),
        .out_  (shift_res)
    );

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_nxt       = state;
        op_data_nxt     = op_data;
        op_shamt_nxt    = op_shamt;
        op_dir_nxt      = op_dir;
        op_port_nxt     = op_port;
        last_served_nxt = last_served;
        gnt0_nxt        = 1'b0;
        gnt1_nxt        = 1'b0;
        valid_nxt       = 1'b0;
        out_nxt         = out_;
        owner_nxt       = owner;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    op_port_nxt  = win;
                    op_data_nxt  = win ? data1  : data0;
                    op_shamt_nxt = win ? shamt1 : shamt0;
                    op_dir_nxt   = win ? dir1   : dir0;
                    gnt0_nxt     = ~win;
                    gnt1_nxt     = win;
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                // valid is set here so that it is high during the DONE cycle.
                out_nxt   = shift_res;
                owner_nxt = op_port;
                valid_nxt = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                last_served_nxt = owner;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: registers update with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_data     <= '0;
            op_shamt    <= '0;
            op_dir      <= 1'b0;
            op_port     <= 1'b0;
            last_served <= 1'b1;   // port 0 wins the first contention
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            valid       <= 1'b0;
            out_        <= '0;
            owner       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            op_data     <= op_data_nxt;
            op_shamt    <= op_shamt_nxt;
            op_dir      <= op_dir_nxt;
            op_port     <= op_port_nxt;
            last_served <= last_served_nxt;
            gnt0        <= gnt0_nxt;
            gnt1        <= gnt1_nxt;
            valid       <= valid_nxt;
            out_        <= out_nxt;
            owner       <= owner_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: doc/barrel_arb.md
BARREL_ARB -- requirements
Module: barrel_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with clock and reset ports listed first:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous active-high reset.
REQ-002 The block SHALL provide one requester port 0:
- req0  input  1  port 0 request; held high until gnt0.
- data0  input  8  port 0 operand.
- shamt0  input  3  port 0 shift amount, 0..7.
- dir0  input  1  port 0 direction; 0 = left, 1 = right.
REQ-003 The block SHALL provide requester port 1 (req1, data1, shamt1, dir1) with the same widths and meanings as port 0.
REQ-004 The block SHALL provide these outputs:
- gnt0  output  1  one-cycle pulse; port 0 operands captured.
- gnt1  output  1  one-cycle pulse; port 1 operands captured.
- out_  output  8  registered shift result.
- valid  output  1  one-cycle pulse; out_ and owner are meaningful.
- owner  output  1  port that owns the current out_.
- busy  output  1  high whenever the state is not IDLE.
REQ-005 All outputs SHALL be driven from registers.

Function
REQ-006 The shift operation SHALL be a logical shift with zero fill: dir=0 gives data<<shamt, dir=1 gives data>>shamt, truncated to 8 bits.
REQ-007 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, and SHALL leave each state on a single clock edge.
REQ-008 IDLE with no request pending SHALL remain in IDLE.
REQ-009 IDLE with any request pending SHALL:
- choose a winner;
- capture that port's data, shamt and dir into operand registers;
- set gnt<winner> for the next cycle;
- go to SHIFT.
REQ-010 SHIFT SHALL load the barrel result of the captured operands into out_, set owner, and go to DONE.
REQ-011 DONE SHALL assert valid for exactly that cycle, update the round-robin pointer to the owner, and go to IDLE.
REQ-012 Latency SHALL be fixed:
- request sampled at edge N;
- gnt high in cycle N+1;
- valid high in cycle N+2;
- next grant no earlier than cycle N+4;
- throughput is one operation per 3 cycles.
REQ-013 When both ports request in the same IDLE cycle, the grant SHALL go to the port not served last.
REQ-014 When only one port requests, that port SHALL be granted regardless of the round-robin pointer.
REQ-015 Requests arriving while not in IDLE SHALL be held off (no gnt) and arbitrated on return to IDLE.
REQ-016 A req still high in the cycle after its gnt SHALL be treated as a new request.
REQ-017 Operand changes after the capture edge SHALL NOT affect out_.
REQ-018 shamt=0 SHALL pass data through unchanged.
REQ-019 out_ and owner SHALL hold their values outside DONE until the next SHIFT overwrites them.
REQ-020 At most one of gnt0 and gnt1 SHALL be high in any cycle, and gnt SHALL never be high in the same cycle as valid.

Reset
REQ-021 While rst is high, the block SHALL immediately force:
- state to IDLE;
- gnt0, gnt1, valid, busy, owner to 0;
- out_ and operand registers to 8'h00;
- round-robin pointer to "last served = port 1", so port 0 wins first.
REQ-022 Reset asserted in SHIFT or DONE SHALL abort the operation: no valid pulse and no pointer update after release.
REQ-023 The first arbitration SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-024 A shared package SHALL hold:
- state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
- DIR_LEFT=1'b0 and DIR_RIGHT=1'b1;
- width constants DW=8 and SW=3.
REQ-025 The shifter SHALL be a separate purely combinational sub-module named barrel (inp_[7:0], shamt[2:0], dir, out_[7:0]), instantiated once and fed from the operand registers.
REQ-026 Arbitration, FSM and output registers SHALL live in barrel_arb.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Port 0 left: req0, data0=8'h96, shamt0=3, dir0=0 at edge N -> gnt0 in N+1; valid, out_=8'hB0, owner=0 in N+2.
- Port 1 right: req1, data1=8'hF0, shamt1=4, dir1=1 -> out_=8'h0F, owner=1, valid exactly 1 cycle.
- Boundaries: 8'hFF shamt=7 left -> 8'h80; 8'hA5 shamt=0 -> 8'hA5; 8'h81 shamt=7 right -> 8'h01.
- Contention: both ports held high from reset -> grants alternate 0,1,0,1, one grant every 3 cycles, never both.
- Single requester: req1 held high alone -> gnt1 every 3rd cycle; input changes after gnt do not alter out_.
- Mid-op reset: rst pulsed during SHIFT -> outputs 0 at once, no valid; after release both ports request -> port 0 granted first.
